imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate-generation path: packs a 32-bit immediate value into the instruction immediate fields selected by an Itype.
- Checks range and alignment before packing.
- Used by the self-test instruction generator and the branch-offset patcher to build LoongArch instructions from a template plus a value.
- Two-stage elastic pipeline with valid/ready on both sides, plus a saturating error counter.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_tmpl  input  32  instruction template; bits outside the selected field are preserved
- in_itype  input  Itype  field selector from cpuDefine: I8, I12, I14, I16, I20, I21, I26, other
- in_unsign  input  1  I12 only: unsigned range check
- in_imm  input  32  immediate value (byte offset for I14/I16/I26)
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_instr  output  32  packed instruction
- out_range_err  output  1  immediate out of range for the field
- out_align_err  output  1  low bits that must be zero were nonzero
- err_cnt  output  ERR_CNT_W  count of results delivered with any error flag set; saturates

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_instr=0, both error flags=0, err_cnt=0.
  - in_ready=1 once reset is deasserted.
- S1 (accept stage): registers in_tmpl, in_itype, in_unsign and in_imm, and computes both error flags.
- S2 (output stage): registers the merged instruction and the flags. out_* are driven directly from S2 registers.
- Latency: a beat accepted at edge N appears as out_valid after edge N+2 if there is no stall.
- Throughput: 1 beat per cycle.
- Advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances when s2 loads.
  - in_ready = !s1_valid || s2 load (combinational).
  - Data is never dropped or duplicated under backpressure.
  - out_* stay stable while out_valid && !out_ready.
- Field packing (template field bits are overwritten; all other bits are kept):
  - I8: instr[14:10]=imm[4:0]. Range: 0..31 unsigned.
  - I12: instr[21:10]=imm[11:0]. Range: 0..4095 if unsign, otherwise -2048..2047.
  - I14: instr[23:10]=imm[15:2]. Align: imm[1:0]=0. Range: signed 16-bit.
  - I16: instr[25:10]=imm[17:2]. Align: imm[1:0]=0. Range: signed 18-bit.
  - I20: instr[24:5]=imm[31:12]. Align: imm[11:0]=0. No range error.
  - I21: instr[25:10]=imm[15:0], instr[4:0]=imm[20:16]. Range: signed 21-bit.
  - I26: instr[25:10]=imm[17:2], instr[9:0]=imm[27:18]. Align: imm[1:0]=0. Range: signed 28-bit.
  - Other itype: out_instr=in_tmpl, both flags 0.
- On an error the field is still packed with truncated bits; both flags can be set together.
- err_cnt increments by 1 on each output handshake with (range_err || align_err). It holds at all-ones when saturated.
- flush: clears s1_valid and s2_valid next edge and discards in-flight beats.
  - err_cnt is not changed.
  - A beat offered in the same cycle as flush is not accepted (in_ready=0 while flush=1).
  - An out handshake coinciding with flush still counts.
- Reset asserted mid-operation discards all beats immediately (asynchronous).

Test Plan:
- I26, tmpl=0x50000000, imm=0xFFFFFFFC, out_ready=1 -> out_instr=0x53FFFFFF, no errors, out_valid 2 cycles after accept.
- I12 signed, tmpl=0x02800000, imm=2048 -> out_instr=0x02A00000, range_err=1, err_cnt=1. Same with unsign=1 -> range_err=0.
- I14, tmpl=0, imm=6 -> out_instr=0x00000400, align_err=1, range_err=0. I20, tmpl=0x14000000, imm=0x12345000 -> 0x142468A0, no errors.
- Stream 8 back-to-back I8 beats imm=0..7 with out_ready low for cycles 3-6 -> in_ready drops once both stages are full; outputs are 0..7 in order with none lost; out_* held stable during the stall.
- flush asserted with both stages valid -> out_valid=0 next cycle, err_cnt unchanged, next accepted beat emerges normally.
- ERR_CNT_W=2, five erroneous beats -> err_cnt sequence 1,2,3,3,3. Assert rst_n low mid-stream -> out_valid=0 and err_cnt=0 without a clock edge.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the LoongArch instruction field chosen by itype, flagging range/alignment errors.
// Latency: a beat presented in the cycle after edge N is registered in S1 at edge N+1 and visible on out_* after edge N+2; 1 beat/cycle.
// Backpressure: two-stage elastic valid/ready pipeline; in_ready falls only when both stages are full and out_ready is low.
//
// Ports:
//   clk, rst_n (async active-low), flush (sync pipeline clear)
//   in_valid/in_ready   : request handshake; in_tmpl, in_itype, in_unsign, in_imm are the request payload
//   out_valid/out_ready : result handshake; out_instr, out_range_err, out_align_err are the result payload
//   err_cnt             : saturating count of delivered results carrying any error flag
//
// in_itype encoding: 0=I8 1=I12 2=I14 3=I16 4=I20 5=I21 6=I26 7=other (template passed through)
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_tmpl,
    input  logic [2:0]           in_itype,
    input  logic                 in_unsign,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_range_err,
    output logic                 out_align_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] ITYPE_I8  = 3'd0;
    localparam logic [2:0] ITYPE_I12 = 3'd1;
    localparam logic [2:0] ITYPE_I14 = 3'd2;
    localparam logic [2:0] ITYPE_I16 = 3'd3;
    localparam logic [2:0] ITYPE_I20 = 3'd4;
    localparam logic [2:0] ITYPE_I21 = 3'd5;
    localparam logic [2:0] ITYPE_I26 = 3'd6;

    // S1 registers
    logic        s1_valid_q;
    logic [31:0] s1_tmpl_q;
    logic [2:0]  s1_itype_q;
    logic        s1_unsign_q;
    logic [31:0] s1_imm_q;

    // S2 registers (drive out_* directly)
    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic        s2_range_q;
    logic        s2_align_q;

    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic        s2_load;
    logic        s1_free;
    logic        accept;
    logic        out_hs;

    logic [31:0] s2_instr_d;
    logic        s2_range_d;
    logic        s2_align_d;

    // Handshake control
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_free  = !s1_valid_q || s2_load;
    assign in_ready = s1_free && !flush;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;

    // Field packing and checks, evaluated on the S1 contents.
    // A signed N-bit range check passes when imm[31:N-1] is all zeros or all ones.
    always_comb begin
        s2_instr_d = s1_tmpl_q;
        s2_range_d = 1'b0;
        s2_align_d = 1'b0;
        case (s1_itype_q)
            ITYPE_I8: begin
                s2_instr_d[14:10] = s1_imm_q[4:0];
                s2_range_d        = |s1_imm_q[31:5];
            end
            ITYPE_I12: begin
                s2_instr_d[21:10] = s1_imm_q[11:0];
                if (s1_unsign_q) begin
                    s2_range_d = |s1_imm_q[31:12];
                end else begin
                    s2_range_d = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
                end
            end
            ITYPE_I14: begin
                s2_instr_d[23:10] = s1_imm_q[15:2];
                s2_align_d        = |s1_imm_q[1:0];
                s2_range_d        = !((&s1_imm_q[31:15]) || !(|s1_imm_q[31:15]));
            end
            ITYPE_I16: begin
                s2_instr_d[25:10] = s1_imm_q[17:2];
                s2_align_d        = |s1_imm_q[1:0];
                s2_range_d        = !((&s1_imm_q[31:17]) || !(|s1_imm_q[31:17]));
            end
            ITYPE_I20: begin
                s2_instr_d[24:5] = s1_imm_q[31:12];
                s2_align_d       = |s1_imm_q[11:0];
            end
            ITYPE_I21: begin
                s2_instr_d[25:10] = s1_imm_q[15:0];
                s2_instr_d[4:0]   = s1_imm_q[20:16];
                s2_range_d        = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));
            end
            ITYPE_I26: begin
                s2_instr_d[25:10] = s1_imm_q[17:2];
                s2_instr_d[9:0]   = s1_imm_q[27:18];
                s2_align_d        = |s1_imm_q[1:0];
                s2_range_d        = !((&s1_imm_q[31:27]) || !(|s1_imm_q[31:27]));
            end
            default: begin
                s2_instr_d = s1_tmpl_q;
            end
        endcase
    end

    // Counts every delivered erroneous result, including one delivered in a flush cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_hs && (s2_range_q || s2_align_q) && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_tmpl_q   <= '0;
            s1_itype_q  <= '0;
            s1_unsign_q <= 1'b0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_range_q  <= 1'b0;
            s2_align_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;

            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (s2_load) begin
                    s2_valid_q <= s1_valid_q;
                end
                if (s1_free) begin
                    s1_valid_q <= in_valid;
                end
            end

            if (accept) begin
                s1_tmpl_q   <= in_tmpl;
                s1_itype_q  <= in_itype;
                s1_unsign_q <= in_unsign;
                s1_imm_q    <= in_imm;
            end

            // S2 payload only changes when a real beat moves in, so a stalled result stays put.
            if (s2_load && s1_valid_q && !flush) begin
                s2_instr_q <= s2_instr_d;
                s2_range_q <= s2_range_d;
                s2_align_q <= s2_align_d;
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_instr     = s2_instr_q;
    assign out_range_err = s2_range_q;
    assign out_align_err = s2_align_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed steps plus a randomized stream checked
// against a queue-based reference model computed from the field/range rules.
module tb_imm_encoder;

    localparam int W = 2;
    localparam int CNT_MAX = (1 << W) - 1;

    localparam logic [2:0] T_I8  = 3'd0;
    localparam logic [2:0] T_I12 = 3'd1;
    localparam logic [2:0] T_I14 = 3'd2;
    localparam logic [2:0] T_I16 = 3'd3;
    localparam logic [2:0] T_I20 = 3'd4;
    localparam logic [2:0] T_I21 = 3'd5;
    localparam logic [2:0] T_I26 = 3'd6;
    localparam logic [2:0] T_OTH = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_tmpl = '0;
    logic [2:0]    in_itype = '0;
    logic          in_unsign = 1'b0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic          out_range_err;
    logic          out_align_err;
    logic [W-1:0]  err_cnt;

    imm_encoder #(.ERR_CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tmpl(in_tmpl), .in_itype(in_itype), .in_unsign(in_unsign), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_range_err(out_range_err), .out_align_err(out_align_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic        r;
        logic        a;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    int          m_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] held_ins;
    logic        held_r, held_a;
    logic        acc;
    logic        saw_nrdy;
    int          idx;
    logic [31:0] rimm;
    int          k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic fits(input longint v, input int bits);
        longint lim;
        lim = longint'(1) << (bits - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    // Reference: clear the field bits in the template, OR in the value slices, and
    // judge range/alignment on the integer value of the immediate.
    function automatic exp_t ref_pack(input logic [31:0] tm, input logic [2:0] it,
                                      input logic u, input logic [31:0] im);
        exp_t   e;
        longint s;
        longint uv;
        s  = longint'($signed(im));
        uv = longint'(im);
        e.ins = tm; e.r = 1'b0; e.a = 1'b0;
        case (it)
            T_I8: begin
                e.ins = (tm & ~(32'h1F << 10)) | ((im % 32) << 10);
                e.r   = uv > 31;
            end
            T_I12: begin
                e.ins = (tm & ~(32'hFFF << 10)) | ((im & 32'hFFF) << 10);
                e.r   = u ? (uv > 4095) : !fits(s, 12);
            end
            T_I14: begin
                e.ins = (tm & ~(32'h3FFF << 10)) | (((im >> 2) & 32'h3FFF) << 10);
                e.a   = (im % 4) != 0;
                e.r   = !fits(s, 16);
            end
            T_I16: begin
                e.ins = (tm & ~(32'hFFFF << 10)) | (((im >> 2) & 32'hFFFF) << 10);
                e.a   = (im % 4) != 0;
                e.r   = !fits(s, 18);
            end
            T_I20: begin
                e.ins = (tm & ~(32'hFFFFF << 5)) | ((im >> 12) << 5);
                e.a   = (im % 4096) != 0;
            end
            T_I21: begin
                e.ins = (tm & ~((32'hFFFF << 10) | 32'h1F))
                      | ((im & 32'hFFFF) << 10) | ((im >> 16) & 32'h1F);
                e.r   = !fits(s, 21);
            end
            T_I26: begin
                e.ins = (tm & 32'hFC00_0000)
                      | (((im >> 2) & 32'hFFFF) << 10) | ((im >> 18) & 32'h3FF);
                e.a   = (im % 4) != 0;
                e.r   = !fits(s, 28);
            end
            default: ;
        endcase
        return e;
    endfunction

    // One clock of scoreboarded streaming; entered and left at posedge+1.
    task automatic stream_cycle(input logic iv, input logic [31:0] tm, input logic [2:0] it,
                                input logic u, input logic [31:0] im, input logic ordy,
                                output logic accepted);
        exp_t e;
        in_valid = iv; in_tmpl = tm; in_itype = it; in_unsign = u; in_imm = im;
        out_ready = ordy; flush = 1'b0;
        #1;
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_instr", out_instr, held_ins);
            chk("hold_flags", {30'd0, out_range_err, out_align_err}, {30'd0, held_r, held_a});
        end
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_instr", out_instr, e.ins);
                chk("out_range", 32'(out_range_err), 32'(e.r));
                chk("out_align", 32'(out_align_err), 32'(e.a));
                if (e.r || e.a) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end
        end
        held     = out_valid && !out_ready;
        held_ins = out_instr;
        held_r   = out_range_err;
        held_a   = out_align_err;
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(ref_pack(tm, it, u, im));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 12 && q.size() != 0; i++) stream_cycle(1'b0, 0, T_OTH, 1'b0, 0, 1'b1, a);
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    // Single beat with full latency check; entered and left at posedge+1.
    task automatic send_one(input string tag, input logic [31:0] tm, input logic [2:0] it,
                            input logic u, input logic [31:0] im, input logic [31:0] ei,
                            input logic er, input logic ea, input int ecnt);
        in_valid = 1'b1; in_tmpl = tm; in_itype = it; in_unsign = u; in_imm = im;
        out_ready = 1'b1; flush = 1'b0;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_vld_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, ei);
        chk({tag, "_range"}, 32'(out_range_err), 32'(er));
        chk({tag, "_align"}, 32'(out_align_err), 32'(ea));
        @(posedge clk); #1;
        chk({tag, "_cnt"}, 32'(err_cnt), 32'(ecnt));
        chk({tag, "_vld_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_flags", {30'd0, out_range_err, out_align_err}, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        q.delete(); m_cnt = 0; held = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        do_reset();

        // Directed field packing
        send_one("i26", 32'h5000_0000, T_I26, 1'b0, 32'hFFFF_FFFC, 32'h53FF_FFFF, 1'b0, 1'b0, 0);
        send_one("i12s", 32'h0280_0000, T_I12, 1'b0, 32'd2048, 32'h02A0_0000, 1'b1, 1'b0, 1);
        send_one("i12u", 32'h0280_0000, T_I12, 1'b1, 32'd2048, 32'h02A0_0000, 1'b0, 1'b0, 1);
        send_one("i14", 32'h0, T_I14, 1'b0, 32'd6, 32'h0000_0400, 1'b0, 1'b1, 2);
        send_one("i20", 32'h1400_0000, T_I20, 1'b0, 32'h1234_5000, 32'h1424_68A0, 1'b0, 1'b0, 2);
        send_one("oth", 32'hDEAD_BEEF, T_OTH, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);

        // Saturation of the 2-bit counter
        do_reset();
        send_one("sat1", 32'h0, T_I8, 1'b0, 32'd32, 32'h0, 1'b1, 1'b0, 1);
        send_one("sat2", 32'h0, T_I8, 1'b0, 32'd33, 32'h0000_0400, 1'b1, 1'b0, 2);
        send_one("sat3", 32'h0, T_I8, 1'b0, 32'd34, 32'h0000_0800, 1'b1, 1'b0, 3);
        send_one("sat4", 32'h0, T_I8, 1'b0, 32'd35, 32'h0000_0C00, 1'b1, 1'b0, 3);
        send_one("sat5", 32'h0, T_I16, 1'b0, 32'h0004_0001, 32'h0000_0000, 1'b1, 1'b1, 3);

        // Back-to-back I8 stream with a stall on cycles 3..6
        do_reset();
        idx = 0; saw_nrdy = 1'b0;
        for (int c = 0; c < 30 && (idx < 8 || q.size() != 0); c++) begin
            if (idx < 8 && !((q.size() < 2) || !(c >= 3 && c <= 6))) saw_nrdy = 1'b1;
            stream_cycle(idx < 8, 32'hA5A5_A5A5, T_I8, 1'b0, 32'(idx), !(c >= 3 && c <= 6), acc);
            if (acc) idx++;
        end
        chk("stall_all_sent", 32'(idx), 32'd8);
        chk("stall_saw_nrdy", 32'(saw_nrdy), 32'd1);
        drain();

        // Flush with both stages holding erroneous beats, nothing delivered
        stream_cycle(1'b1, 32'h0, T_I8, 1'b0, 32'd100, 1'b0, acc);
        stream_cycle(1'b1, 32'h0, T_I8, 1'b0, 32'd101, 1'b0, acc);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_err_cnt", 32'(err_cnt), 32'(m_cnt));
        q.delete(); held = 1'b0;

        // Flush coinciding with an erroneous output handshake still counts
        stream_cycle(1'b1, 32'h0, T_I8, 1'b0, 32'd200, 1'b0, acc);
        stream_cycle(1'b1, 32'h0, T_I8, 1'b0, 32'd201, 1'b0, acc);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_cnt = m_cnt + 1;
        chk("flush_hs_cnt", 32'(err_cnt), 32'(m_cnt));
        chk("flush_hs_valid", 32'(out_valid), 32'd0);
        q.delete(); held = 1'b0;
        send_one("post_flush", 32'h0, T_I21, 1'b0, 32'h000A_BCDE, 32'h02F3_780A, 1'b0, 1'b0, m_cnt);

        // Randomized stream against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            k = $urandom_range(2, 30);
            rimm = $urandom & ((32'd1 << k) - 32'd1);
            if ($urandom_range(0, 1) == 1) rimm = -rimm;
            if ($urandom_range(0, 1) == 1) rimm = rimm & ~32'd3;
            if ($urandom_range(0, 7) == 0) rimm = $urandom;
            stream_cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), rimm, $urandom_range(0, 9) < 7, acc);
        end
        drain();

        // Asynchronous reset mid-stream
        for (int c = 0; c < 4; c++) stream_cycle(1'b1, 32'h0, T_I8, 1'b0, 32'd50, 1'b0, acc);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt", 32'(err_cnt), 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
